// File: rtl/hanoi_move_gen.sv
// Optimal Tower-of-Hanoi move generator: streams the 2^N-1 moves that carry N disks
// from peg 0 to peg 2 over valid/ready, keeping per-peg disk counts.
//
// state | meaning
// IDLE  | waiting for start after reset, no move offered
// RUN   | offering move m on mv_fr/mv_to/mv_disk
// DONE  | tower sits on peg 2, waiting for a restart
module hanoi_move_gen #(
    parameter int N = 4,
    localparam int DW = $clog2(N),
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mv_valid,
    input  logic          mv_ready,
    output logic [1:0]    mv_fr,
    output logic [1:0]    mv_to,
    output logic [DW-1:0] mv_disk,
    output logic [N-1:0]  move_cnt,
    output logic [CW-1:0] peg0_cnt,
    output logic [CW-1:0] peg1_cnt,
    output logic [CW-1:0] peg2_cnt,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N:0] FIRST = (N + 1)'(1);
    localparam logic [N:0] LAST  = {1'b0, {N{1'b1}}};
    localparam logic [N:0] THREE = (N + 1)'(3);

    state_t        state, state_nxt;
    logic [N:0]    m;
    logic [N:0]    m_next;
    logic [CW-1:0] peg [3];

    // The bit formulas move the tower onto peg 2 for odd N; even N needs pegs 1/2 swapped.
    function automatic logic [1:0] swap12(input logic [1:0] p);
        return ((N % 2 == 0) && (p != 2'd0)) ? 2'd3 - p : p;
    endfunction

    function automatic logic [1:0] src_peg(input logic [N:0] k);
        return swap12(2'((k & (k - 1'b1)) % THREE));
    endfunction

    function automatic logic [1:0] dst_peg(input logic [N:0] k);
        return swap12(2'(((k | (k - 1'b1)) + 1'b1) % THREE));
    endfunction

    function automatic logic [DW-1:0] disk_of(input logic [N-1:0] k);
        logic [DW-1:0] tz;
        tz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (k[i]) tz = DW'(i);
        end
        return tz;
    endfunction

    assign m_next = m + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (mv_ready && (m == LAST)) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m        <= '0;
            mv_fr    <= 2'd0;
            mv_to    <= 2'd0;
            mv_disk  <= '0;
            move_cnt <= '0;
            peg[0]   <= CW'(N);
            peg[1]   <= '0;
            peg[2]   <= '0;
        end else if ((state != RUN) && start) begin
            m        <= FIRST;
            mv_fr    <= src_peg(FIRST);
            mv_to    <= dst_peg(FIRST);
            mv_disk  <= disk_of(FIRST[N-1:0]);
            move_cnt <= '0;
            peg[0]   <= CW'(N);
            peg[1]   <= '0;
            peg[2]   <= '0;
        end else if ((state == RUN) && mv_ready) begin
            move_cnt <= move_cnt + 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (mv_fr == 2'(i))      peg[i] <= peg[i] - 1'b1;
                else if (mv_to == 2'(i)) peg[i] <= peg[i] + 1'b1;
            end
            // Last move stays on the outputs through DONE.
            if (m != LAST) begin
                m       <= m_next;
                mv_fr   <= src_peg(m_next);
                mv_to   <= dst_peg(m_next);
                mv_disk <= disk_of(m_next[N-1:0]);
            end
        end
    end

    assign mv_valid = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign peg0_cnt = peg[0];
    assign peg1_cnt = peg[1];
    assign peg2_cnt = peg[2];

endmodule

// File: tb/tb_hanoi_move_gen.sv
// Bench for hanoi_move_gen: N=2,3,4 instances checked against an iterative
// three-stack Hanoi model (smallest disk cycles, otherwise the only legal move).
module tb_hanoi_move_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, mv_ready;
    int   sel;
    int   total = 0;
    int   bad = 0;

    logic st2, st3, st4;
    assign st2 = start && (sel == 2);
    assign st3 = start && (sel == 3);
    assign st4 = start && (sel == 4);

    logic       v2, b2, d2;
    logic [1:0] fr2, to2, mc2, p02, p12, p22;
    logic [0:0] dk2;
    logic       v3, b3, d3;
    logic [1:0] fr3, to3, dk3, p03, p13, p23;
    logic [2:0] mc3;
    logic       v4, b4, d4;
    logic [1:0] fr4, to4, dk4;
    logic [3:0] mc4;
    logic [2:0] p04, p14, p24;

    hanoi_move_gen #(.N(2)) dut2 (.clk(clk), .rst(rst), .start(st2), .mv_valid(v2), .mv_ready(mv_ready),
        .mv_fr(fr2), .mv_to(to2), .mv_disk(dk2), .move_cnt(mc2), .peg0_cnt(p02), .peg1_cnt(p12),
        .peg2_cnt(p22), .busy(b2), .done(d2));
    hanoi_move_gen #(.N(3)) dut3 (.clk(clk), .rst(rst), .start(st3), .mv_valid(v3), .mv_ready(mv_ready),
        .mv_fr(fr3), .mv_to(to3), .mv_disk(dk3), .move_cnt(mc3), .peg0_cnt(p03), .peg1_cnt(p13),
        .peg2_cnt(p23), .busy(b3), .done(d3));
    hanoi_move_gen #(.N(4)) dut4 (.clk(clk), .rst(rst), .start(st4), .mv_valid(v4), .mv_ready(mv_ready),
        .mv_fr(fr4), .mv_to(to4), .mv_disk(dk4), .move_cnt(mc4), .peg0_cnt(p04), .peg1_cnt(p14),
        .peg2_cnt(p24), .busy(b4), .done(d4));

    int o_valid, o_busy, o_done, o_fr, o_to, o_disk, o_cnt, o_p0, o_p1, o_p2;
    always_comb begin
        {o_valid, o_busy, o_done, o_fr, o_to, o_disk, o_cnt, o_p0, o_p1, o_p2} = '0;
        case (sel)
            2: begin
                o_valid = int'(v2); o_busy = int'(b2); o_done = int'(d2); o_fr = int'(fr2);
                o_to = int'(to2); o_disk = int'(dk2); o_cnt = int'(mc2);
                o_p0 = int'(p02); o_p1 = int'(p12); o_p2 = int'(p22);
            end
            3: begin
                o_valid = int'(v3); o_busy = int'(b3); o_done = int'(d3); o_fr = int'(fr3);
                o_to = int'(to3); o_disk = int'(dk3); o_cnt = int'(mc3);
                o_p0 = int'(p03); o_p1 = int'(p13); o_p2 = int'(p23);
            end
            default: begin
                o_valid = int'(v4); o_busy = int'(b4); o_done = int'(d4); o_fr = int'(fr4);
                o_to = int'(to4); o_disk = int'(dk4); o_cnt = int'(mc4);
                o_p0 = int'(p04); o_p1 = int'(p14); o_p2 = int'(p24);
            end
        endcase
    end

    // Reference model: three stacks, top of stack at index sz[p]-1.
    int stk [3][16];
    int sz [3];
    int efr, eto, edisk;

    task automatic model_init(input int n);
        for (int p = 0; p < 3; p++) sz[p] = 0;
        for (int d = n - 1; d >= 0; d--) begin
            stk[0][sz[0]] = d;
            sz[0]++;
        end
    endtask

    task automatic model_pick(input int n, input int k);
        int a, b, p0;
        p0 = 0;
        for (int p = 0; p < 3; p++)
            if (sz[p] > 0 && stk[p][sz[p]-1] == 0) p0 = p;
        if (k % 2 == 1) begin
            efr = p0;
            eto = (n % 2 == 0) ? (p0 + 1) % 3 : (p0 + 2) % 3;
        end else begin
            a = (p0 + 1) % 3;
            b = (p0 + 2) % 3;
            if (sz[a] == 0)      begin efr = b; eto = a; end
            else if (sz[b] == 0) begin efr = a; eto = b; end
            else if (stk[a][sz[a]-1] < stk[b][sz[b]-1]) begin efr = a; eto = b; end
            else                 begin efr = b; eto = a; end
        end
        edisk = stk[efr][sz[efr]-1];
    endtask

    task automatic model_apply();
        int d;
        d = stk[efr][sz[efr]-1];
        sz[efr]--;
        total++;
        if (sz[eto] > 0 && stk[eto][sz[eto]-1] < d) begin
            bad++;
            $display("FAIL legality: disk %0d onto disk %0d at peg %0d", d, stk[eto][sz[eto]-1], eto);
        end
        stk[eto][sz[eto]] = d;
        sz[eto]++;
    endtask

    // Starts DUT n, then checks every offered move against the model until stop transfers.
    task automatic drive_moves(input int n, input bit rnd, input int stop, input int poke, output int cyc);
        int xfers;
        bit rdy;
        model_init(n);
        model_pick(n, 1);
        xfers = 0;
        cyc = 0;
        sel = n;
        mv_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (xfers < stop && cyc < 400) begin
            total++;
            if ({o_valid, o_busy, o_done} !== {32'd1, 32'd1, 32'd0}) begin
                bad++;
                $display("FAIL run_flags n=%0d move=%0d: valid/busy/done=%0d%0d%0d want 110",
                         n, xfers + 1, o_valid, o_busy, o_done);
            end
            total++;
            if (o_fr !== efr || o_to !== eto || o_disk !== edisk) begin
                bad++;
                $display("FAIL move n=%0d move=%0d: got %0d>%0d disk %0d want %0d>%0d disk %0d",
                         n, xfers + 1, o_fr, o_to, o_disk, efr, eto, edisk);
            end
            total++;
            if (o_cnt !== xfers || o_p0 !== sz[0] || o_p1 !== sz[1] || o_p2 !== sz[2]) begin
                bad++;
                $display("FAIL counts n=%0d move=%0d: cnt=%0d pegs=(%0d,%0d,%0d) want cnt=%0d pegs=(%0d,%0d,%0d)",
                         n, xfers + 1, o_cnt, o_p0, o_p1, o_p2, xfers, sz[0], sz[1], sz[2]);
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            mv_ready = rdy;
            if (xfers == poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (rdy) begin
                model_apply();
                xfers++;
                if (xfers < (1 << n) - 1) model_pick(n, xfers + 1);
            end
        end
        mv_ready = 1'b0;
        if (xfers < stop) begin
            total++;
            bad++;
            $display("FAIL timeout n=%0d: transfers=%0d want %0d", n, xfers, stop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        mv_ready = 1'b0;
        sel = 4;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({o_valid, o_busy, o_done, o_fr, o_to, o_disk, o_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%0d busy=%0d done=%0d mv=%0d>%0d disk=%0d cnt=%0d want all 0",
                     o_valid, o_busy, o_done, o_fr, o_to, o_disk, o_cnt);
        end
        for (int n = 2; n <= 4; n++) begin
            sel = n;
            #1;
            total++;
            if (o_p0 !== n || o_p1 !== 0 || o_p2 !== 0) begin
                bad++;
                $display("FAIL reset_pegs n=%0d: (%0d,%0d,%0d) want (%0d,0,0)", n, o_p0, o_p1, o_p2, n);
            end
        end
    endtask

    task automatic test_n3_full();
        int c;
        drive_moves(3, 1'b0, 7, -1, c);
        total++;
        if (c !== 7) begin
            bad++;
            $display("FAIL n3_cycles: took %0d cycles want 7", c);
        end
        total++;
        if (o_valid !== 0 || o_busy !== 0 || o_done !== 1 || o_cnt !== 7 ||
            o_p0 !== 0 || o_p1 !== 0 || o_p2 !== 3) begin
            bad++;
            $display("FAIL n3_done: v=%0d b=%0d d=%0d cnt=%0d pegs=(%0d,%0d,%0d) want 0 0 1 7 (0,0,3)",
                     o_valid, o_busy, o_done, o_cnt, o_p0, o_p1, o_p2);
        end
    endtask

    task automatic test_n2_full();
        int c;
        drive_moves(2, 1'b0, 3, -1, c);
        total++;
        if (o_valid !== 0 || o_done !== 1 || o_cnt !== 3 || o_p0 !== 0 || o_p1 !== 0 || o_p2 !== 2) begin
            bad++;
            $display("FAIL n2_done: v=%0d d=%0d cnt=%0d pegs=(%0d,%0d,%0d) want 0 1 3 (0,0,2)",
                     o_valid, o_done, o_cnt, o_p0, o_p1, o_p2);
        end
    endtask

    task automatic test_n4_random_stall();
        int c;
        drive_moves(4, 1'b1, 15, -1, c);
        total++;
        if (o_valid !== 0 || o_busy !== 0 || o_done !== 1 || o_cnt !== 15 ||
            o_p0 !== 0 || o_p1 !== 0 || o_p2 !== 4) begin
            bad++;
            $display("FAIL n4_rand_done: v=%0d b=%0d d=%0d cnt=%0d pegs=(%0d,%0d,%0d) want 0 0 1 15 (0,0,4)",
                     o_valid, o_busy, o_done, o_cnt, o_p0, o_p1, o_p2);
        end
        repeat (3) @(negedge clk);
        total++;
        if (o_done !== 1 || o_cnt !== 15 || o_p2 !== 4) begin
            bad++;
            $display("FAIL n4_done_hold: d=%0d cnt=%0d peg2=%0d want 1 15 4", o_done, o_cnt, o_p2);
        end
    endtask

    task automatic test_restart_from_done();
        int c;
        drive_moves(4, 1'b1, 15, -1, c);
        total++;
        if (o_done !== 1 || o_cnt !== 15 || o_p0 !== 0 || o_p2 !== 4) begin
            bad++;
            $display("FAIL restart_done: d=%0d cnt=%0d pegs=(%0d,%0d,%0d) want 1 15 (0,0,4)",
                     o_done, o_cnt, o_p0, o_p1, o_p2);
        end
    endtask

    task automatic test_start_while_busy();
        int c;
        drive_moves(4, 1'b0, 15, 3, c);
        total++;
        if (c !== 15 || o_done !== 1 || o_cnt !== 15 || o_p2 !== 4) begin
            bad++;
            $display("FAIL busy_start: cycles=%0d d=%0d cnt=%0d peg2=%0d want 15 1 15 4",
                     c, o_done, o_cnt, o_p2);
        end
    endtask

    task automatic test_reset_mid_run();
        int c;
        drive_moves(4, 1'b0, 6, -1, c);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (o_valid !== 0 || o_busy !== 0 || o_done !== 0 || o_cnt !== 0 ||
            o_p0 !== 4 || o_p1 !== 0 || o_p2 !== 0) begin
            bad++;
            $display("FAIL abort: v=%0d b=%0d d=%0d cnt=%0d pegs=(%0d,%0d,%0d) want 0 0 0 0 (4,0,0)",
                     o_valid, o_busy, o_done, o_cnt, o_p0, o_p1, o_p2);
        end
        repeat (2) @(negedge clk);
        drive_moves(4, 1'b0, 15, -1, c);
        total++;
        if (o_done !== 1 || o_cnt !== 15 || o_p0 !== 0 || o_p1 !== 0 || o_p2 !== 4) begin
            bad++;
            $display("FAIL abort_fresh: d=%0d cnt=%0d pegs=(%0d,%0d,%0d) want 1 15 (0,0,4)",
                     o_done, o_cnt, o_p0, o_p1, o_p2);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mv_ready = 1'b0;
        sel = 4;
        test_reset();
        test_n3_full();
        test_n2_full();
        test_n4_random_stall();
        test_restart_from_done();
        test_start_while_busy();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
